// File: rtl/trng_keygen.sv
// trng_keygen: XOR-combined TRNG sampler with RCT/APT health tests and key handoff.
// Optional Von Neumann debiasing is built when TRNG_VON_NEUMANN_EN is defined.
module trng_keygen #(
  parameter int N_CH        = 4,
  parameter int KEY_WIDTH   = 512,
  parameter int RCT_CUTOFF  = 32,
  parameter int APT_HI      = 300,
  parameter int FAIL_THRESH = 11
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic [N_CH-1:0]                  raw_bits_i,
  input  logic                             raw_valid_i,
  output logic                             sample_en_o,
  output logic [KEY_WIDTH-1:0]             key_o,
  output logic                             key_valid_o,
  input  logic                             key_ack_i,
  output logic                             error_o,
  output logic                             total_failure_o,
  output logic [$clog2(FAIL_THRESH+1)-1:0] fail_cnt_o,
  output logic                             intr_o
);

  localparam int CW = $clog2(KEY_WIDTH+1);
  localparam int RW = $clog2(RCT_CUTOFF+1);
  localparam int FW = $clog2(FAIL_THRESH+1);

  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_WIDTH-1);
  localparam logic [CW-1:0] ONES_MAX = CW'(APT_HI);
  localparam logic [CW-1:0] ONES_MIN = CW'(KEY_WIDTH-APT_HI);
  localparam logic [RW-1:0] RUN_CUT  = RW'(RCT_CUTOFF);
  localparam logic [FW-1:0] FAIL_MAX = FW'(FAIL_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_READY,
    S_FAIL
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_sr_q, key_sr_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]        ones_q, ones_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 prev_q, prev_d;
  logic                 rct_fail_q, rct_fail_d;
  logic [FW-1:0]        fail_cnt_q, fail_cnt_d;
  logic                 sample_en_q, sample_en_d;
  logic                 key_valid_q, key_valid_d;
  logic                 error_q, error_d;
  logic                 tf_q, tf_d;
  logic                 intr_q, intr_d;
`ifdef TRNG_VON_NEUMANN_EN
  logic                 vn_have_q, vn_have_d;
  logic                 vn_first_q, vn_first_d;
`endif

  logic          comb_bit;
  logic          accept;
  logic          bit_vld;
  logic          bit_val;
  logic [RW-1:0] run_n;
  logic [CW-1:0] ones_n;
  logic [FW-1:0] fail_inc;
  logic          key_bad;
  logic          clr;

  // Next-state, health-test and output decode
  always_comb begin
    state_d     = state_q;
    key_sr_d    = key_sr_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    run_d       = run_q;
    prev_d      = prev_q;
    rct_fail_d  = rct_fail_q;
    fail_cnt_d  = fail_cnt_q;
    error_d     = 1'b0;
    intr_d      = 1'b0;
    clr         = 1'b0;
    comb_bit    = ^raw_bits_i;
    accept      = (state_q == S_COLLECT) && enable_i && raw_valid_i;
`ifdef TRNG_VON_NEUMANN_EN
    vn_have_d   = vn_have_q;
    vn_first_d  = vn_first_q;
    bit_vld     = accept && vn_have_q && (vn_first_q != comb_bit);
    bit_val     = vn_first_q;
    if (accept) begin
      vn_have_d  = ~vn_have_q;
      vn_first_d = comb_bit;
    end
`else
    bit_vld     = accept;
    bit_val     = comb_bit;
`endif
    run_n    = (bit_cnt_q == '0 || bit_val != prev_q) ? RW'(1) : run_q + RW'(1);
    ones_n   = ones_q + CW'(bit_val);
    fail_inc = fail_cnt_q + FW'(1);
    key_bad  = rct_fail_q || (ones_q > ONES_MAX) || (ones_q < ONES_MIN);

    unique case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (enable_i) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (bit_vld) begin
          key_sr_d  = {key_sr_q[KEY_WIDTH-2:0], bit_val};
          bit_cnt_d = bit_cnt_q + CW'(1);
          ones_d    = ones_n;
          run_d     = run_n;
          prev_d    = bit_val;
          if (run_n == RUN_CUT || bit_cnt_q == LAST_BIT) begin
            state_d    = S_CHECK;
            rct_fail_d = (run_n == RUN_CUT);
          end
        end
      end
      S_CHECK: begin
        if (key_bad) begin
          error_d    = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d = S_FAIL;
            intr_d  = 1'b1;
          end else begin
            state_d = enable_i ? S_COLLECT : S_IDLE;
            clr     = 1'b1;
          end
        end else begin
          fail_cnt_d = '0;
          state_d    = S_READY;
          intr_d     = 1'b1;
        end
      end
      S_READY: begin
        if (key_ack_i) begin
          state_d = enable_i ? S_COLLECT : S_IDLE;
          clr     = 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      key_sr_d   = '0;
      bit_cnt_d  = '0;
      ones_d     = '0;
      run_d      = '0;
      prev_d     = 1'b0;
      rct_fail_d = 1'b0;
    end
`ifdef TRNG_VON_NEUMANN_EN
    if (state_d != S_COLLECT) vn_have_d = 1'b0;
`endif

    sample_en_d = (state_d == S_COLLECT);
    key_valid_d = (state_d == S_READY);
    tf_d        = (state_d == S_FAIL);
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      key_sr_q    <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      run_q       <= '0;
      prev_q      <= 1'b0;
      rct_fail_q  <= 1'b0;
      fail_cnt_q  <= '0;
      sample_en_q <= 1'b0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      tf_q        <= 1'b0;
      intr_q      <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
      vn_have_q   <= 1'b0;
      vn_first_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_sr_q    <= key_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      rct_fail_q  <= rct_fail_d;
      fail_cnt_q  <= fail_cnt_d;
      sample_en_q <= sample_en_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
      tf_q        <= tf_d;
      intr_q      <= intr_d;
`ifdef TRNG_VON_NEUMANN_EN
      vn_have_q   <= vn_have_d;
      vn_first_q  <= vn_first_d;
`endif
    end
  end

  assign sample_en_o     = sample_en_q;
  assign key_valid_o     = key_valid_q;
  assign key_o           = key_valid_q ? key_sr_q : '0;
  assign error_o         = error_q;
  assign total_failure_o = tf_q;
  assign fail_cnt_o      = fail_cnt_q;
  assign intr_o          = intr_q;

endmodule

// File: tb/tb_trng_keygen.sv
// tb_trng_keygen: directed stimulus with a queue-based reference model.
// Default build covers the direct path; TRNG_VON_NEUMANN_EN runs the debias case.
module tb_trng_keygen;
  localparam int NCH  = 4;
  localparam int KW   = 512;
  localparam int RCT  = 32;
  localparam int APTH = 300;
  localparam int FT   = 11;
  localparam int FCW  = $clog2(FT+1);

  localparam int P_IDLE = 0;
  localparam int P_COL  = 1;
  localparam int P_CHK  = 2;
  localparam int P_RDY  = 3;
  localparam int P_FAIL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni      = 1'b0;
  logic           enable_i    = 1'b0;
  logic           raw_valid_i = 1'b0;
  logic           key_ack_i   = 1'b0;
  logic [NCH-1:0] raw_bits_i  = '0;
  logic           sample_en_o;
  logic [KW-1:0]  key_o;
  logic           key_valid_o;
  logic           error_o;
  logic           total_failure_o;
  logic [FCW-1:0] fail_cnt_o;
  logic           intr_o;

  trng_keygen #(
    .N_CH(NCH), .KEY_WIDTH(KW), .RCT_CUTOFF(RCT),
    .APT_HI(APTH), .FAIL_THRESH(FT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .raw_bits_i(raw_bits_i), .raw_valid_i(raw_valid_i),
    .sample_en_o(sample_en_o), .key_o(key_o),
    .key_valid_o(key_valid_o), .key_ack_i(key_ack_i),
    .error_o(error_o), .total_failure_o(total_failure_o),
    .fail_cnt_o(fail_cnt_o), .intr_o(intr_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [KW-1:0] act,
                     input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: spec rules over a queue of collected bits
  int            m_ph   = P_IDLE;
  bit            m_q[$];
  int            m_fail = 0;
  bit            m_rct  = 1'b0;
  bit            m_vh   = 1'b0;
  bit            m_vf   = 1'b0;
  logic [KW-1:0] m_key  = '0;
  bit            e_err  = 1'b0;
  bit            e_intr = 1'b0;

  function automatic int tail_run();
    int r = 0;
    for (int k = m_q.size() - 1; k >= 0; k--) begin
      if (m_q[k] == m_q[m_q.size()-1]) r++;
      else break;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit b;
    bit nb;
    bit have;
    int ones;
    e_err  = 1'b0;
    e_intr = 1'b0;
    if (!rst_ni) begin
      m_ph   = P_IDLE;
      m_q.delete();
      m_fail = 0;
      m_rct  = 1'b0;
      m_vh   = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: if (enable_i) begin
          m_ph  = P_COL;
          m_q.delete();
          m_rct = 1'b0;
          m_vh  = 1'b0;
        end
        P_COL: begin
          if (!enable_i) begin
            m_ph = P_IDLE;
            m_vh = 1'b0;
          end else if (raw_valid_i) begin
            b    = ^raw_bits_i;
            nb   = b;
            have = 1'b1;
`ifdef TRNG_VON_NEUMANN_EN
            if (!m_vh) begin
              m_vh = 1'b1;
              m_vf = b;
              have = 1'b0;
            end else begin
              m_vh = 1'b0;
              have = (m_vf != b);
              nb   = m_vf;
            end
`endif
            if (have) begin
              m_q.push_back(nb);
              if (tail_run() >= RCT) m_rct = 1'b1;
              if (m_rct || m_q.size() == KW) begin
                m_ph = P_CHK;
                m_vh = 1'b0;
              end
            end
          end
        end
        P_CHK: begin
          ones = 0;
          foreach (m_q[k]) ones += int'(m_q[k]);
          if (m_rct || ones > APTH || ones < KW - APTH) begin
            m_fail++;
            e_err = 1'b1;
            if (m_fail == FT) begin
              m_ph   = P_FAIL;
              e_intr = 1'b1;
            end else begin
              m_ph  = enable_i ? P_COL : P_IDLE;
              m_q.delete();
              m_rct = 1'b0;
            end
          end else begin
            m_fail = 0;
            e_intr = 1'b1;
            m_ph   = P_RDY;
            m_key  = '0;
            foreach (m_q[k]) m_key[KW-1-k] = m_q[k];
          end
        end
        P_RDY: if (key_ack_i) begin
          m_ph  = enable_i ? P_COL : P_IDLE;
          m_q.delete();
          m_rct = 1'b0;
        end
        default: ;
      endcase
    end
    #1;
    chk("sample_en", KW'(sample_en_o), KW'(m_ph == P_COL));
    chk("key_valid", KW'(key_valid_o), KW'(m_ph == P_RDY));
    chk("key", key_o, (m_ph == P_RDY) ? m_key : '0);
    chk("error", KW'(error_o), KW'(e_err));
    chk("total_failure", KW'(total_failure_o), KW'(m_ph == P_FAIL));
    chk("fail_cnt", KW'(fail_cnt_o), KW'(m_fail));
    chk("intr", KW'(intr_o), KW'(e_intr));
  end

  // Stimulus
  int mode = 0;
  int idx  = 0;

  function automatic logic [NCH-1:0] gen(input int md, input int i);
    logic [NCH-1:0] v;
    v = '0;
    case (md)
      1: v[0] = (i % 2) == 1;
      2: begin
        v[0]     = (i % 4) != 3;
        v[NCH-1] = 1'b1;
        v[NCH-2] = 1'b1;
      end
      3: v[0] = ((i % 6) == 1) || ((i % 6) == 2);
      default: ;
    endcase
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    raw_bits_i = gen(mode, idx);
    idx++;
  endtask

  task automatic start(input int md);
    @(negedge clk);
    enable_i    = 1'b1;
    raw_valid_i = 1'b1;
    raw_bits_i  = '0;
    mode        = md;
    idx         = 0;
  endtask

  task automatic wait_valid(input int lim, output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (!key_valid_o && c < lim);
  endtask

  logic [KW-1:0] k55;
  logic [KW-1:0] kaa;

  initial begin
    int c;
    int errs;
    int mx;
    k55 = {(KW/4){4'h5}};
    kaa = {(KW/4){4'hA}};
    repeat (3) @(negedge clk);
    chk("rst_valid", KW'(key_valid_o), '0);
    chk("rst_key", key_o, '0);
    chk("rst_sen", KW'(sample_en_o), '0);
    chk("rst_cnt", KW'(fail_cnt_o), '0);
    rst_ni = 1'b1;
    step();
`ifdef TRNG_VON_NEUMANN_EN
    start(3);
    wait_valid(2000, c);
    chk("vn_latency", KW'(c), KW'(1536));
    chk("vn_key", key_o, k55);
    enable_i  = 1'b0;
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    chk("vn_ack", KW'(key_valid_o), '0);
    step();
`else
    start(1);
    wait_valid(600, c);
    chk("t1_latency", KW'(c), KW'(514));
    chk("t1_key", key_o, k55);
    chk("t1_intr", KW'(intr_o), KW'(1));
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    chk("t1_ack_valid", KW'(key_valid_o), '0);
    chk("t1_ack_key", key_o, '0);
    enable_i = 1'b0;
    repeat (3) step();

    start(1);
    repeat (100) step();
    step();
    enable_i = 1'b0;
    step();
    chk("t4_idle_sen", KW'(sample_en_o), '0);
    chk("t4_idle_valid", KW'(key_valid_o), '0);
    repeat (3) step();
    start(1);
    wait_valid(600, c);
    chk("t4_latency", KW'(c), KW'(514));
    enable_i = 1'b0;
    repeat (4) step();
    chk("t4_hold_valid", KW'(key_valid_o), KW'(1));
    chk("t4_hold_key", key_o, k55);
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    chk("t4_ack_valid", KW'(key_valid_o), '0);
    step();
    chk("t4_ack_sen", KW'(sample_en_o), '0);

    start(1);
    wait_valid(600, c);
    chk("t5_latency", KW'(c), KW'(514));
    rst_ni   = 1'b0;
    enable_i = 1'b0;
    step();
    chk("t5_valid", KW'(key_valid_o), '0);
    chk("t5_key", key_o, '0);
    chk("t5_intr", KW'(intr_o), '0);
    chk("t5_sen", KW'(sample_en_o), '0);
    rst_ni = 1'b1;
    step();

    start(2);
    c = 0;
    do begin
      step();
      c++;
    end while (!error_o && c < 600);
    chk("t3_err_cycle", KW'(c), KW'(514));
    chk("t3_cnt", KW'(fail_cnt_o), KW'(1));
    chk("t3_restart", KW'(sample_en_o), KW'(1));
    mode = 1;
    wait_valid(600, c);
    chk("t3_latency", KW'(c), KW'(513));
    chk("t3_key", key_o, kaa);
    chk("t3_cnt_clr", KW'(fail_cnt_o), '0);
    enable_i  = 1'b0;
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    step();

    start(0);
    c    = 0;
    errs = 0;
    mx   = 0;
    do begin
      step();
      c++;
      if (error_o) errs++;
      if (!total_failure_o && int'(fail_cnt_o) > mx) mx = int'(fail_cnt_o);
    end while (!total_failure_o && c < 1000);
    chk("t2_fail_cycle", KW'(c), KW'(364));
    chk("t2_errs", KW'(errs), KW'(11));
    chk("t2_max_cnt", KW'(mx), KW'(10));
    chk("t2_intr", KW'(intr_o), KW'(1));
    for (int i = 0; i < 6; i++) begin
      enable_i = ~enable_i;
      step();
    end
    chk("t2_sticky", KW'(total_failure_o), KW'(1));
    chk("t2_no_sample", KW'(sample_en_o), '0);
    rst_ni   = 1'b0;
    enable_i = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("t2_rst_tf", KW'(total_failure_o), '0);
    chk("t2_rst_cnt", KW'(fail_cnt_o), '0);
    step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
